// File: rtl/avalon_master_pkg.sv
// Shared types for the Avalon-MM load/store initiator.
// Size codes, FSM states and byte-lane masks.
package avalon_master_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/avalon_lane_mux.sv
// Byte-lane steering for stores and extract/extend for loads.
// Purely combinational; also flags misaligned or illegal sizes.
module avalon_lane_mux
    import avalon_master_pkg::*;
(
    input  logic [1:0]  lane,
    input  size_t       size,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {lane, 3'b000};
    assign shifted = rdata >> shamt;

    always_comb begin
        misaligned = 1'b0;
        byteenable = 4'b0000;
        writedata  = 32'h0;
        load_data  = 32'h0;
        unique case (1'b1)
            size == BYTE: begin
                byteenable = BE_BYTE << lane;
                writedata  = {24'h0, wdata[7:0]} << shamt;
                load_data  = {{24{sext & shifted[7]}},
                              shifted[7:0]};
            end
            size == HALF: begin
                misaligned = lane[0];
                byteenable = lane[1] ? BE_HI : BE_LO;
                writedata  = {16'h0, wdata[15:0]} << shamt;
                load_data  = {{16{sext & shifted[15]}},
                              shifted[15:0]};
            end
            size == WORD: begin
                misaligned = (lane != 2'b00);
                byteenable = BE_ALL;
                writedata  = wdata;
                load_data  = rdata;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/avalon_mem_master.sv
// Avalon-MM initiator for single CPU loads/stores.
// IDLE -> BUS -> RESP with a forced idle cycle between transfers.
module avalon_mem_master
    import avalon_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    state_t      state;
    logic [1:0]  lat_lane;
    size_t       lat_size;
    logic        lat_signed;
    logic [31:0] tmo_cnt;

    logic [1:0]  mux_lane;
    size_t       mux_size;
    logic        mux_signed;
    logic        mux_err;
    logic [3:0]  mux_be;
    logic [31:0] mux_wdata;
    logic [31:0] mux_rdata;
    logic        timed_out;

    assign req_ready = (state == IDLE);

    // Steer from the live request while idle, from the latch afterwards.
    assign mux_lane   = req_ready ? req_addr[1:0] : lat_lane;
    assign mux_size   = req_ready ? size_t'(req_size) : lat_size;
    assign mux_signed = req_ready ? req_signed : lat_signed;

    assign timed_out = (TIMEOUT != 0) && waitrequest &&
                       (tmo_cnt == TIMEOUT - 1);

    avalon_lane_mux u_lane_mux (
        .lane       (mux_lane),
        .size       (mux_size),
        .sext       (mux_signed),
        .wdata      (req_wdata),
        .rdata      (readdata),
        .misaligned (mux_err),
        .byteenable (mux_be),
        .writedata  (mux_wdata),
        .load_data  (mux_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_lane   <= 2'b00;
            lat_size   <= BYTE;
            lat_signed <= 1'b0;
            tmo_cnt    <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= 32'h0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_lane   <= req_addr[1:0];
                        lat_size   <= size_t'(req_size);
                        lat_signed <= req_signed;
                        if (mux_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state      <= BUS;
                            tmo_cnt    <= 32'h0;
                            read       <= ~req_write;
                            write      <= req_write;
                            address    <= {req_addr[31:2], 2'b00};
                            byteenable <= mux_be;
                            writedata  <= mux_wdata;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        state     <= RESP;
                        read      <= 1'b0;
                        write     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= read ? mux_rdata : 32'h0;
                    end else if (timed_out) begin
                        state     <= RESP;
                        read      <= 1'b0;
                        write     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_rdata <= 32'h0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mem_master.sv
// Bench for avalon_mem_master: directed plan plus random
// transactions against a byte-level memory reference model.
module tb_avalon_mem_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    int   tests = 0;
    int   fails = 0;
    int   wait_cfg = 0;
    int   wcnt = 0;
    logic force_wait = 1'b0;
    int   rises = 0;
    int   rises_exp = 0;
    logic prev_busy = 1'b0;

    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    logic [31:0] obs_rd;

    avalon_mem_master #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .address     (address),
        .byteenable  (byteenable),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    assign readdata = mem[address[7:2]];

    // Slave: stall wait_cfg cycles per transfer, then complete.
    always @(negedge clk) begin
        if (read || write) begin
            if (force_wait || wcnt < wait_cfg) begin
                waitrequest = 1'b1;
                wcnt = wcnt + 1;
            end else begin
                waitrequest = 1'b0;
            end
        end else begin
            wcnt = 0;
            waitrequest = force_wait;
        end
        if ((read || write) && !prev_busy)
            rises = rises + 1;
        prev_busy = read || write;
    end

    always @(posedge clk) begin
        if (write && !waitrequest) begin
            for (int i = 0; i < 4; i++)
                if (byteenable[i])
                    mem[address[7:2]][8*i +: 8] = writedata[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w,
        input logic [1:0] lane, input int nb, input logic sg);
        int unsigned v, top;
        if (nb == 4) return w;
        v = (w >> (8 * lane)) % (32'd1 << (8 * nb));
        top = 32'd1 << (8 * nb - 1);
        if (sg && v >= top) return v - 2 * top;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] lane,
                                          input int nb);
        int unsigned m;
        m = (nb == 4) ? 15 : (((32'd1 << nb) - 1) << lane);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wd(input logic [31:0] wd,
        input logic [1:0] lane, input int nb);
        if (nb == 4) return wd;
        return (wd % (32'd1 << (8 * nb))) << (8 * lane);
    endfunction

    task automatic setw(input logic [31:0] a, input logic [31:0] v);
        mem[a[7:2]] = v;
        ref_mem[a[7:2]] = v;
    endtask

    task automatic xact(input logic wr, input logic [31:0] a,
        input logic [1:0] sz, input logic sg,
        input logic [31:0] wd, input int nw);
        logic illegal, tmo, exp_err, bad, got, o_err;
        int nb, lat, busy, exp_lat, exp_busy;
        logic [31:0] exp_addr, exp_wd, exp_rd, o_rd;
        logic [3:0] exp_be;
        logic [5:0] idx;
        nb = nbytes(sz);
        illegal = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                  (sz == 2'd2 && a[1:0] != 2'd0);
        tmo = force_wait && !illegal;
        exp_err = illegal || tmo;
        idx = a[7:2];
        exp_addr = {a[31:2], 2'b00};
        exp_be = ref_be(a[1:0], nb);
        exp_wd = ref_wd(wd, a[1:0], nb);
        exp_rd = (exp_err || wr) ? 32'h0 :
                 ref_load(ref_mem[idx], a[1:0], nb, sg);
        exp_lat = illegal ? 1 : tmo ? TMO + 1 : nw + 2;
        exp_busy = illegal ? 0 : tmo ? TMO : nw + 1;
        if (!illegal) rises_exp++;
        if (wr && !exp_err)
            for (int i = 0; i < 4; i++)
                if (exp_be[i]) ref_mem[idx][8*i +: 8] = exp_wd[8*i +: 8];
        wait_cfg = nw;
        check("ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr = a;
        req_size = sz;
        req_signed = sg;
        req_wdata = wd;
        @(posedge clk); #1;
        // Held request with junk fields must be ignored outside IDLE.
        req_addr = $urandom;
        req_wdata = $urandom;
        req_size = 2'($urandom);
        req_signed = 1'($urandom);
        got = 1'b0; bad = 1'b0; lat = 0; busy = 0;
        o_rd = 32'h0; o_err = 1'b0;
        for (int c = 1; c <= 64 && !got; c++) begin
            if (read || write) begin
                busy++;
                if (address !== exp_addr || byteenable !== exp_be ||
                    read !== !wr || write !== wr ||
                    (wr && writedata !== exp_wd))
                    bad = 1'b1;
                obs_be = byteenable;
                obs_wd = writedata;
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                o_rd = rsp_rdata;
                o_err = rsp_error;
            end else begin
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
        obs_rd = o_rd;
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("bus_cycles", 32'(busy), 32'(exp_busy));
        check("bus_fields", 32'(bad), 32'd0);
        check("rsp_error", 32'(o_err), 32'(exp_err));
        check("rsp_rdata", o_rd, exp_rd);
        @(posedge clk); #1;
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic saw;
        int   bad_words;
        logic [31:0] a;
        logic [1:0]  sz;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'h0;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            a = $urandom;
            mem[i] = a;
            ref_mem[i] = a;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_read", 32'(read), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_address", address, 32'h0);
        check("rst_be", 32'(byteenable), 32'h0);
        check("rst_wdata", writedata, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);

        setw(32'hBFC00004, 32'h12345678);
        xact(1'b0, 32'hBFC00004, 2'd2, 1'b0, 32'h0, 3);
        check("tp_word_load", obs_rd, 32'h12345678);

        setw(32'hBFC00004, 32'h0);
        xact(1'b1, 32'hBFC00006, 2'd0, 1'b0, 32'h000000AB, 1);
        check("tp_store_be", 32'(obs_be), 32'h4);
        check("tp_store_wd", obs_wd, 32'h00AB0000);
        check("tp_store_ram", mem[6'd1], 32'h00AB0000);

        setw(32'hBFC00008, 32'h80000000);
        xact(1'b0, 32'hBFC0000B, 2'd0, 1'b1, 32'h0, 0);
        check("tp_sbyte", obs_rd, 32'hFFFFFF80);
        xact(1'b0, 32'hBFC0000B, 2'd0, 1'b0, 32'h0, 0);
        check("tp_ubyte", obs_rd, 32'h00000080);
        setw(32'hBFC0000C, 32'h80010000);
        xact(1'b0, 32'hBFC0000E, 2'd1, 1'b1, 32'h0, 2);
        check("tp_shalf", obs_rd, 32'hFFFF8001);

        xact(1'b0, 32'hBFC00002, 2'd2, 1'b0, 32'h0, 0);
        xact(1'b0, 32'hBFC00000, 2'd3, 1'b0, 32'h0, 0);
        xact(1'b1, 32'hBFC00011, 2'd1, 1'b0, 32'h1234, 0);

        force_wait = 1'b1;
        xact(1'b0, 32'hBFC00010, 2'd2, 1'b0, 32'h0, 0);
        force_wait = 1'b0;
        xact(1'b0, 32'hBFC00010, 2'd2, 1'b0, 32'h0, 1);

        // Reset while the bus transfer is stalled.
        wait_cfg = 6;
        rises_exp++;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'hBFC00014;
        req_size = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_bus_read", 32'(read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_drop_read", 32'(read), 32'd0);
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) saw = 1'b1;
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        if (rsp_valid) saw = 1'b1;
        check("rst_no_rsp", 32'(saw), 32'd0);
        check("rst_ready_after", 32'(req_ready), 32'd1);

        xact(1'b0, 32'hBFC00020, 2'd2, 1'b0, 32'h0, 0);
        xact(1'b0, 32'hBFC00024, 2'd2, 1'b0, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom_range(0, 3));
            a = {24'hBFC000, 8'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            xact(1'($urandom), a, sz, 1'($urandom), $urandom,
                 $urandom_range(0, 4));
        end

        bad_words = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i]) bad_words++;
        check("ram_contents", 32'(bad_words), 32'd0);
        check("bus_rises", 32'(rises), 32'(rises_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avalon_mem_master.md
# avalon_mem_master

Avalon-MM initiator that turns single CPU load/store requests into Avalon read/write transactions against the Avalon memory model and on-chip RAM. It sits between the CPU memory stage and the data bus. It handles byte/halfword/word sizing, byte-lane steering and sign/zero extension. It holds bus signals stable across `waitrequest`, enforces an idle cycle between transactions, and reports misalignment and bus-timeout errors.

## Interface
- `TIMEOUT`, 1024: cycles of continuous `waitrequest` before abort; 0 disables the timeout.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  block can accept a request (IDLE only).
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend load result.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_error`  out  1  misaligned, illegal size or timeout; valid with `rsp_valid`.
- `address`  out  32  `{req_addr[31:2], 2'b00}`.
- `byteenable`  out  4  active lanes.
- `read`  out  1  Avalon read.
- `write`  out  1  Avalon write.
- `writedata`  out  32  lane-steered store data.
- `waitrequest`  in  1  slave stall.
- `readdata`  in  32  slave read data.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, the request is latched.
  - Legal request → BUS.
  - Illegal request (size 11, half with addr[0]=1, word with addr[1:0]≠0) → RESP with `rsp_error`=1, without driving `read` or `write`.
- BUS: `read` or `write`=1. `address`, `byteenable` and `writedata` are registered and constant for the whole state.
  - Completion at the rising edge where `waitrequest`=0. For reads, `readdata` is captured at that edge. → RESP.
- RESP: `read`=`write`=0, `rsp_valid`=1 for exactly one cycle → IDLE.
  - Guarantees at least one deasserted cycle between transactions, so the slave sees a fresh rising edge on `read`/`write`.
- Lane rule, with lane = `addr[1:0]`:
  - byte: `byteenable` = 1<<lane.
  - half: `byteenable` = addr[1] ? 1100 : 0011.
  - word: `byteenable` = 1111.
  - `writedata` = `req_wdata` << 8·lane; non-enabled lanes are 0.
- Load result: `readdata` >> 8·lane, masked to size, then sign-extended if `req_signed`, else zero-extended. `req_signed` is ignored for words.
- Timeout: a counter clears on entering BUS and increments each BUS cycle with `waitrequest`=1.
  - When the count reaches `TIMEOUT` (nonzero), go to RESP with `rsp_error`=1 and `rsp_rdata`=0; the transaction is abandoned.
- Requests arriving outside IDLE are ignored; `req_ready`=0 there.

## Timing
- Reset (async assert, sync release): state IDLE, `read`=`write`=0, `address`=0, `byteenable`=0, `writedata`=0, `rsp_valid`=0, `rsp_error`=0, `rsp_rdata`=0, counter 0; `req_ready`=1.
- Reset mid-BUS drops `read`/`write` immediately and no response is issued.
- Latency:
  - Accept edge → `read`/`write` high the next cycle.
  - With N cycles of `waitrequest`, `rsp_valid` occurs N+2 cycles after accept.
  - Error path: `rsp_valid` 1 cycle after accept.
- Minimum issue interval: 3 cycles per transaction (IDLE, BUS, RESP).
- `waitrequest` is only sampled in BUS. A `waitrequest` already high on entry simply extends BUS.
- All outputs are registered except `req_ready` (decoded from state).

## Structure
- Package `avalon_master_pkg`: `size_t` enum (BYTE, HALF, WORD, ILLEGAL), `state_t` enum (IDLE, BUS, RESP), lane-mask constants.
- Sub-module `avalon_lane_mux`, combinational: provides the alignment check, `byteenable`/`writedata` generation and load extract/extend. It is unit-testable in isolation.
- Top module contains the FSM, request latch and timeout counter.

## Test plan
- Word load at 0xBFC00004, RAM word 0x12345678, slave wait 3 cycles → `read` held 4 cycles with `address`=0xBFC00004 and `byteenable`=1111 stable; `rsp_rdata`=0x12345678 at accept+5.
- Byte store 0xAB to 0xBFC00006 → `byteenable`=0100, `writedata`=0x00AB0000; RAM word becomes 0x00AB0000 from 0; `rsp_error`=0.
- Signed byte load at lane 3 of word 0x80000000 → 0xFFFFFF80; unsigned → 0x00000080; signed half at lane 2 of 0x8001_0000 → 0xFFFF8001.
- Word load at 0xBFC00002 and size 11 → no `read` pulse; `rsp_valid` with `rsp_error`=1 one cycle after accept.
- `waitrequest` forced high, `TIMEOUT`=8 → `read` dropped after 8 wait cycles; `rsp_error`=1, `rsp_rdata`=0; next request accepted normally.
- `reset_n` low during BUS → `read`=0 immediately, no `rsp_valid`; after release `req_ready`=1 and back-to-back loads leave ≥1 idle cycle between `read` pulses.
